// File: rtl/seg7_pkg.sv
// Seven-segment constants and parameter helpers shared by the digit counter
// and its decoder.
package seg7_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bit radix_legal(input int radix);
        return (radix == 10) || (radix == 16);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One 4-bit digit to an active-low seven-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[digit];

endmodule

// File: rtl/updown_digit_counter.sv
// Multi-digit hex/BCD up/down counter with an internal tick divider,
// synchronous load, wrap pulse and per-digit seven-segment outputs.
module updown_digit_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int RADIX    = 16,
    parameter int TICK_DIV = 25000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int              DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]      D_MAX    = 4'(RADIX - 1);

    if (!radix_legal(RADIX) || TICK_DIV < 2 || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
        $error("updown_digit_counter: illegal RADIX/TICK_DIV/DIGITS");
    end

    logic [DIV_W-1:0]    div;
    logic [DIGITS-1:0]   lim;
    logic [4*DIGITS-1:0] count_nxt;
    logic [4*DIGITS-1:0] load_clean;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] d;
        logic [3:0] ld;
        logic       cin;

        assign d  = count[4*i +: 4];
        assign ld = load_val[4*i +: 4];

        // lim: this digit would roll over (up) or underflow (down) if stepped.
        assign lim[i] = up ? (d == D_MAX) : (d == 4'd0);

        if (i == 0) begin : g_lsd
            assign cin = 1'b1;
        end else begin : g_upper
            assign cin = &lim[i-1:0];
        end

        assign count_nxt[4*i +: 4] = !cin ? d :
                                     up   ? (lim[i] ? 4'd0  : d + 4'd1) :
                                            (lim[i] ? D_MAX : d - 4'd1);

        assign load_clean[4*i +: 4] = (ld > D_MAX) ? 4'd0 : ld;

        seg7_decoder u_dec (
            .digit (d),
            .seg   (seg[7*i +: 7])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div   <= '0;
            tick  <= 1'b0;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            tick <= (div == DIV_LAST);
            div  <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (load) begin
                count <= load_clean;
                wrap  <= 1'b0;
            end else if (tick && en) begin
                count <= count_nxt;
                wrap  <= &lim;
            end else begin
                wrap  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_digit_counter.sv
// Bench for updown_digit_counter: a hex and a BCD instance share stimulus and
// are checked every cycle against an integer reference model.
module tb_updown_digit_counter;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int W        = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        en, up, load;
    logic [7:0]  load_val;
    logic [7:0]  count_h, count_b;
    logic        tick_h, tick_b, wrap_h, wrap_b;
    logic [13:0] seg_h, seg_b;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    int m_h, m_b, m_cyc;
    bit m_tick, m_wh, m_wb;
    int tick_seen;

    typedef struct {
        logic [7:0] start;
        bit         dir_up;
        logic [7:0] exp_h;
        bit         wh;
        logic [7:0] exp_b;
        bit         wb;
    } vec_t;
    vec_t vecs [10];

    updown_digit_counter #(.DIGITS(DIGITS), .RADIX(16), .TICK_DIV(TICK_DIV)) dut_hex (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_h), .tick(tick_h), .wrap(wrap_h), .seg(seg_h)
    );

    updown_digit_counter #(.DIGITS(DIGITS), .RADIX(10), .TICK_DIV(TICK_DIV)) dut_bcd (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_b), .tick(tick_b), .wrap(wrap_b), .seg(seg_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sanitize(input logic [7:0] v, input int r);
        int hi, lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi >= r) hi = 0;
        if (lo >= r) lo = 0;
        return hi * r + lo;
    endfunction

    function automatic logic [7:0] enc(input int n, input int r);
        logic [3:0] hi, lo;
        hi = 4'(n / r);
        lo = 4'(n % r);
        return {hi, lo};
    endfunction

    function automatic int step_val(input int n, input int r, input bit u);
        int md;
        md = r * r;
        return u ? (n + 1) % md : (n + md - 1) % md;
    endfunction

    function automatic bit hits_wrap(input int n, input int r, input bit u);
        return u ? (n == r * r - 1) : (n == 0);
    endfunction

    task automatic model_reset();
        m_h = 0; m_b = 0; m_cyc = 0;
        m_tick = 1'b0; m_wh = 1'b0; m_wb = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] e;
        logic [7:0] eh, eb;
        e  = exp_q.pop_front();
        eh = e[15:8];
        eb = e[7:0];
        check("count_hex", 32'(count_h), 32'(eh));
        check("count_bcd", 32'(count_b), 32'(eb));
        check("tick_hex",  32'(tick_h),  32'(m_tick));
        check("tick_bcd",  32'(tick_b),  32'(m_tick));
        check("wrap_hex",  32'(wrap_h),  32'(m_wh));
        check("wrap_bcd",  32'(wrap_b),  32'(m_wb));
        check("seg_hex",   32'(seg_h),   32'({seg_tab[eh[7:4]], seg_tab[eh[3:0]]}));
        check("seg_bcd",   32'(seg_b),   32'({seg_tab[eb[7:4]], seg_tab[eb[3:0]]}));
    endtask

    // ---------------- drivers ----------------
    // One clock edge: advance the model with the inputs currently applied,
    // then compare just after the edge.
    task automatic step();
        if (load) begin
            m_h = sanitize(load_val, 16);
            m_b = sanitize(load_val, 10);
            m_wh = 1'b0; m_wb = 1'b0;
        end else if (m_tick && en) begin
            m_wh = hits_wrap(m_h, 16, up);
            m_wb = hits_wrap(m_b, 10, up);
            m_h  = step_val(m_h, 16, up);
            m_b  = step_val(m_b, 10, up);
        end else begin
            m_wh = 1'b0; m_wb = 1'b0;
        end
        m_cyc++;
        m_tick = (m_cyc % TICK_DIV) == 0;
        exp_q.push_back({enc(m_h, 16), enc(m_b, 10)});
        @(posedge clock);
        #1;
        if (tick_h) tick_seen++;
        check_all();
    endtask

    // Step until the edge that samples a tick has happened.
    task automatic run_tick();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3 * TICK_DIV && !got; k++) begin
            got = m_tick;
            step();
        end
        if (!got) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{8'h00, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0};
        vecs[1] = '{8'h0F, 1'b1, 8'h10, 1'b0, 8'h01, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'hFF, 1'b1, 8'h99, 1'b1};
        vecs[4] = '{8'h09, 1'b1, 8'h0A, 1'b0, 8'h10, 1'b0};
        vecs[5] = '{8'h99, 1'b1, 8'h9A, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h3C, 1'b1, 8'h3D, 1'b0, 8'h31, 1'b0};
        vecs[7] = '{8'h10, 1'b0, 8'h0F, 1'b0, 8'h09, 1'b0};
        vecs[8] = '{8'hA0, 1'b0, 8'h9F, 1'b0, 8'h99, 1'b1};
        vecs[9] = '{8'h42, 1'b0, 8'h41, 1'b0, 8'h41, 1'b0};

        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        tick_seen = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        exp_q.push_back(16'h0000);
        check_all();
        check("reset_seg_hex", 32'(seg_h), 32'(14'b1000000_1000000));

        // Count up through 00..10 in hex.
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 16; k++) run_tick();
        check("seq1_count", 32'(count_h), 32'h10);
        check("seq1_seg0",  32'(seg_h[6:0]), 32'(7'b1000000));

        // Table of load-then-one-tick vectors.
        for (int v = 0; v < 10; v++) begin
            do_load(vecs[v].start);
            if (vecs[v].start == 8'h3C) check("bcd_load_3c", 32'(count_b), 32'h30);
            up = vecs[v].dir_up;
            run_tick();
            check("vec_count_hex", 32'(count_h), 32'(vecs[v].exp_h));
            check("vec_wrap_hex",  32'(wrap_h),  32'(vecs[v].wh));
            check("vec_count_bcd", 32'(count_b), 32'(vecs[v].exp_b));
            check("vec_wrap_bcd",  32'(wrap_b),  32'(vecs[v].wb));
            step();
            check("vec_wrap_drop", 32'({wrap_h, wrap_b}), 32'd0);
        end

        // Load in the tick cycle: load wins, tick consumed.
        up = 1'b1;
        for (int k = 0; k < 3 * TICK_DIV && !m_tick; k++) step();
        check("tick_before_load", 32'(tick_h), 32'd1);
        do_load(8'h42);
        check("load_in_tick_hex", 32'(count_h), 32'h42);
        check("load_in_tick_wrap", 32'(wrap_h), 32'd0);
        run_tick();
        check("after_load_tick", 32'(count_h), 32'h43);

        // en low: ticks keep pulsing, count holds.
        do_load(8'h20);
        en = 1'b0;
        run_tick();
        tick_seen = 0;
        for (int k = 0; k < 3; k++) run_tick();
        check("en0_ticks", 32'(tick_seen), 32'd3);
        check("en0_hold", 32'(count_h), 32'h20);

        // Direction only matters on the tick cycle.
        en = 1'b1; up = 1'b1;
        run_tick();
        up = 1'b0; step();
        up = 1'b1;
        run_tick();
        check("up_toggle_inc", 32'(count_h), 32'h22);
        up = 1'b1; step();
        up = 1'b0;
        run_tick();
        check("up_toggle_dec", 32'(count_h), 32'h21);

        // Async reset between edges at count 57.
        do_load(8'h57);
        up = 1'b1;
        step();
        reset = 1'b1;
        #2;
        check("async_rst_hex", 32'(count_h), 32'h00);
        check("async_rst_bcd", 32'(count_b), 32'h00);
        check("async_rst_tick", 32'({tick_h, wrap_h}), 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
        begin
            int n;
            n = 0;
            while (!tick_h && n < 3 * TICK_DIV) begin
                step();
                n++;
            end
            check("post_reset_tick_edges", 32'(n), 32'(TICK_DIV));
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 7) != 0);
            up   = $urandom_range(0, 1) != 0;
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 8'hFF;
                1:       load_val = 8'h99;
                2:       load_val = 8'h00;
                default: load_val = 8'($urandom_range(0, 255));
            endcase
            step();
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
